// File: rtl/ez90_pkg.sv
// rtl/ez90_pkg.sv - shared eZ90 uop types and the RS issue queue depth
package ez90_pkg;

  // Shared with dispatch credit logic so both sides agree on queue capacity.
  localparam int EZ90_RSQ_DEPTH = 8;

  typedef struct packed {
    logic [7:0]  tag;
    logic [6:0]  opcode;
    logic [5:0]  prd;
    logic [5:0]  prs1;
    logic [5:0]  prs2;
    logic [15:0] imm;
  } ez90_uop_tagged_t;

endpackage

// File: rtl/rs_issue_queue.sv
// rtl/rs_issue_queue.sv - in-order issue buffer between dispatch and the RS port
//   clk, rst           : core clock, synchronous active-high reset
//   flush              : discard every entry; wins over push and pop
//   disp_valid/uop/rdy : dispatch push side
//   rs_valid/uop/ready : oldest entry presented to the scheduler
//   count/full/empty   : occupancy status
module rs_issue_queue
  import ez90_pkg::*;
#(
  parameter int  DEPTH = EZ90_RSQ_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  input  ez90_uop_tagged_t disp_uop,
  output logic             disp_ready,
  output logic             rs_valid,
  output ez90_uop_tagged_t rs_uop,
  input  logic             rs_ready,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  ez90_uop_tagged_t mem_q [DEPTH];
  ez90_uop_tagged_t mem_d [DEPTH];

  logic push;
  logic pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Both handshakes are masked by flush, so flush cycles never transfer.
  // full is taken from the registered count: a pop this cycle does not
  // free a slot for dispatch until the next cycle.
  assign disp_ready = !rst && !flush && !full;
  assign rs_valid   = !rst && !flush && !empty;
  assign rs_uop     = rs_valid ? mem_q[head_q] : '0;

  assign push = disp_valid && disp_ready;
  assign pop  = rs_valid && rs_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q]   = disp_uop;
        valid_d[tail_q] = 1'b1;
        tail_d          = tail_q + PTR_W'(1);
      end
      if (pop) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload is not reset; entries are meaningless while their valid bit is 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    count_q <= CNT_W'(DEPTH));
  a_no_push_full : assert property (@(posedge clk) disable iff (rst)
    !(push && full));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
    !(pop && empty));
  a_head_valid : assert property (@(posedge clk) disable iff (rst)
    valid_q[head_q] == !empty);
  a_rs_uop_stable : assert property (@(posedge clk) disable iff (rst)
    (rs_valid && !rs_ready) |=> (rst || flush || $stable(rs_uop)));
`endif

endmodule

// File: tb/tb_rs_issue_queue.sv
// tb/tb_rs_issue_queue.sv - directed self-checking bench for rs_issue_queue
module tb_rs_issue_queue;
  import ez90_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             disp_valid;
  ez90_uop_tagged_t disp_uop;
  logic             disp_ready;
  logic             rs_valid;
  ez90_uop_tagged_t rs_uop;
  logic             rs_ready;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  int total = 0;
  int bad   = 0;

  rs_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .disp_valid (disp_valid),
    .disp_uop   (disp_uop),
    .disp_ready (disp_ready),
    .rs_valid   (rs_valid),
    .rs_uop     (rs_uop),
    .rs_ready   (rs_ready),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  function automatic ez90_uop_tagged_t mk(input logic [7:0] t);
    ez90_uop_tagged_t u;
    u.tag    = t;
    u.opcode = t[6:0] ^ 7'h55;
    u.prd    = t[5:0] + 6'd1;
    u.prs1   = t[5:0] + 6'd2;
    u.prs2   = t[5:0] + 6'd3;
    u.imm    = {8'hC3, ~t};
    return u;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push tags base..base+n-1 with the scheduler stalled.
  task automatic fill(input logic [7:0] base, input int n);
    rs_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      disp_valid = 1'b1;
      disp_uop   = mk(base + 8'(i));
      #1;
      check("fill_rdy", 64'(disp_ready), 64'd1);
      tick();
    end
    disp_valid = 1'b0;
  endtask

  // Pop n entries, expecting tags base..base+n-1 in order.
  task automatic drain(input logic [7:0] base, input int n);
    disp_valid = 1'b0;
    rs_ready   = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      check("drain_vld", 64'(rs_valid), 64'd1);
      check("drain_uop", 64'(rs_uop), 64'(mk(base + 8'(i))));
      tick();
    end
    rs_ready = 1'b0;
    #1;
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_cnt", 64'(count), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    disp_valid = 1'b0;
    disp_uop   = '0;
    rs_ready   = 1'b0;

    // Reset then idle
    repeat (3) tick();
    check("rst_rdy", 64'(disp_ready), 64'd0);
    check("rst_vld", 64'(rs_valid), 64'd0);
    check("rst_uop", 64'(rs_uop), 64'd0);
    check("rst_cnt", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_rdy", 64'(disp_ready), 64'd1);
    check("post_rst_vld", 64'(rs_valid), 64'd0);

    // Fill to full; first push into an empty queue is not visible yet
    disp_valid = 1'b1;
    disp_uop   = mk(8'd0);
    #1;
    check("empty_push_vld", 64'(rs_valid), 64'd0);
    tick();
    check("lat1_vld", 64'(rs_valid), 64'd1);
    check("lat1_uop", 64'(rs_uop), 64'(mk(8'd0)));
    fill(8'd1, 7);
    disp_valid = 1'b1;
    disp_uop   = mk(8'd8);
    #1;
    check("full_flag", 64'(full), 64'd1);
    check("full_cnt", 64'(count), 64'd8);
    check("full_rdy", 64'(disp_ready), 64'd0);
    tick();
    disp_valid = 1'b0;
    check("ninth_rejected", 64'(count), 64'd8);
    drain(8'd0, 8);

    // Simultaneous push/pop for 20 cycles at count 3
    fill(8'h40, 3);
    disp_valid = 1'b1;
    rs_ready   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      disp_uop = mk(8'h43 + 8'(i));
      #1;
      check("pp_cnt", 64'(count), 64'd3);
      check("pp_uop", 64'(rs_uop), 64'(mk(8'h40 + 8'(i))));
      tick();
    end
    drain(8'h54, 3);

    // Full with pop: no push-through that cycle
    fill(8'h60, 8);
    disp_valid = 1'b1;
    disp_uop   = mk(8'h68);
    rs_ready   = 1'b1;
    #1;
    check("fp_rdy", 64'(disp_ready), 64'd0);
    check("fp_uop", 64'(rs_uop), 64'(mk(8'h60)));
    tick();
    rs_ready = 1'b0;
    check("fp_cnt7", 64'(count), 64'd7);
    check("fp_rdy_next", 64'(disp_ready), 64'd1);
    tick();
    disp_valid = 1'b0;
    check("fp_cnt8", 64'(count), 64'd8);
    drain(8'h61, 8);

    // Backpressure hold
    fill(8'h15, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", 64'(rs_valid), 64'd1);
      check("bp_uop", 64'(rs_uop), 64'(mk(8'h15)));
      tick();
    end
    drain(8'h15, 1);

    // Flush mid-stream
    fill(8'h70, 5);
    flush      = 1'b1;
    disp_valid = 1'b1;
    disp_uop   = mk(8'h77);
    rs_ready   = 1'b1;
    #1;
    check("fl_vld", 64'(rs_valid), 64'd0);
    check("fl_rdy", 64'(disp_ready), 64'd0);
    check("fl_uop", 64'(rs_uop), 64'd0);
    tick();
    flush    = 1'b0;
    rs_ready = 1'b0;
    disp_uop = mk(8'h2A);
    check("fl_cnt", 64'(count), 64'd0);
    check("fl_empty", 64'(empty), 64'd1);
    check("fl_push_vld", 64'(rs_valid), 64'd0);
    tick();
    disp_valid = 1'b0;
    check("fl_new_vld", 64'(rs_valid), 64'd1);
    check("fl_new_uop", 64'(rs_uop), 64'(mk(8'h2A)));
    check("fl_new_cnt", 64'(count), 64'd1);

    // Multi-cycle flush holds the queue empty
    flush = 1'b1;
    repeat (2) tick();
    check("mfl_cnt", 64'(count), 64'd0);
    flush = 1'b0;
    #1;
    check("mfl_vld", 64'(rs_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/rs_issue_queue.md
Name: rs_issue_queue

Overview:
- In-order issue buffer between eZ90 dispatch/rename and the scheduler's RS input port.
- Accepts one tagged uop per cycle from dispatch, holds up to DEPTH entries, and presents the oldest entry to the scheduler on a registered valid/ready interface.
- A full pipeline flush empties the queue in one cycle.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; do not override).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; discards every entry.
- disp_valid  in  1  dispatch presents a uop.
- disp_uop  in  ez90_pkg::ez90_uop_tagged_t  uop from dispatch.
- disp_ready  out  1  queue can accept this cycle.
- rs_valid  out  1  head entry valid (to scheduler rs_valid).
- rs_uop  out  ez90_pkg::ez90_uop_tagged_t  head entry (to scheduler rs_uop).
- rs_ready  in  1  scheduler consumed the head (from scheduler rs_ready).
- count  out  CNT_W  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Clock and reset:
  - One clock; all state updates on posedge clk.
  - Reset is synchronous and active-high.
  - Reset forces head_ptr=0, tail_ptr=0, count=0, and all valid bits to 0.
  - Outputs during and after reset: rs_valid=0, rs_uop='0, count=0, empty=1, full=0, disp_ready=0 while rst=1, disp_ready=1 the first cycle after rst drops.
  - Storage payload is not reset; contents are don't-care while invalid.
- Storage:
  - Circular array of DEPTH entries with head_ptr and tail_ptr of width $clog2(DEPTH).
  - Pointers wrap naturally from DEPTH-1 to 0.
  - count tracks occupancy explicitly; full and empty derive from count, not from pointer compare.
- Handshakes:
  - Push when disp_valid && disp_ready. The entry is written at tail_ptr, then tail_ptr+1.
  - Pop when rs_valid && rs_ready. head_ptr+1.
  - disp_ready = !rst && !flush && !full. There is no push-through when full, even if a pop occurs the same cycle.
  - rs_valid = !empty && !flush. rs_uop = entry[head_ptr] when rs_valid, else '0.
  - rs_uop is driven from storage, with no combinational path from disp_uop.
  - Minimum latency is one cycle: a uop pushed in cycle N is first visible on rs_valid in cycle N+1.
  - rs_uop is held stable while rs_valid=1 and rs_ready=0.
- Count update:
  - Push only: +1. Pop only: -1. Simultaneous push and pop: unchanged, both pointers advance.
  - Full with a pop: count becomes DEPTH-1. disp_ready stays 0 that cycle and goes to 1 the next cycle.
  - Empty with a push: count becomes 1. rs_valid=0 that cycle.
- Flush:
  - Flush has priority over push and pop.
  - In the flush cycle, rs_valid=0 and disp_ready=0, so no transfers occur.
  - Next edge: head_ptr=tail_ptr=0, count=0.
  - Multi-cycle flush holds the queue empty.
  - Flush and rst together behave as rst.
- Assertions (simulation only):
  - count never exceeds DEPTH.
  - No push when full.
  - No pop when empty.
  - rs_uop stable under backpressure.

Decomposition:
- ez90_pkg already supplies ez90_uop_tagged_t.
- Add EZ90_RSQ_DEPTH (default 8) to ez90_pkg so dispatch credit logic and this block agree on the depth.
- No sub-module. The circular buffer and pointer logic are small enough to remain inline.

Test Plan:
- Reset then idle: hold rst for 3 cycles -> rs_valid=0, count=0, empty=1. disp_ready=1 in the first cycle after release.
- Fill and drain, DEPTH=8:
  - Push tags 0..7 back-to-back with rs_ready=0 -> full=1 after the 8th push, disp_ready=0, 9th push rejected.
  - Then rs_ready=1 -> tags 0..7 emerge in order on consecutive cycles, empty=1 after the last.
- Simultaneous push/pop: count=3, then disp_valid=1 and rs_ready=1 for 20 cycles -> count stays 3, output order matches input order, pointers wrap at least twice.
- Full with pop: count=8, rs_ready=1 and disp_valid=1 -> no push that cycle, count=7. Push accepted the next cycle, count=8.
- Backpressure hold: head tag 0x15, rs_ready=0 for 5 cycles -> rs_uop stays 0x15 and rs_valid stays 1 throughout.
- Flush mid-stream: count=5, flush=1 together with disp_valid=1 and rs_ready=1 -> neither transfer occurs, count=0 next cycle. A new push of tag 0x2A appears as the head one cycle later.
